nmr_param_bank: RTL and testbench
=================================

// Module: nmr_param_bank
// PURPOSE
//  Parametrised Avalon-MM bank of NMR sequence parameters (samples per echo, echo count, etc.).
//  - CPU writes shadow registers at any time.
//  - A commit request copies all shadows into the active outputs atomically.
//  - The copy happens only while the pulse sequencer reports idle, so parameters never change mid-sequence.
//  - Sits between the HPS lightweight bridge and the NMR sequencer/ADC capture logic.
// PARAMETERS
//  NUM_REGS    8                 number of parameter registers (1..64)
//  DATA_W      32                parameter width in bits (8..32, multiple of 8)
//  ADDR_W      $clog2(NUM_REGS+1) Avalon word-address width
//  RESET_VALS  {NUM_REGS{32'd255}} packed per-register reset values; reg i uses bits [i*32 +: DATA_W]
// PORTS
//  clk         in   1                 system clock
//  reset       in   1                 synchronous, active-high reset
//  address     in   ADDR_W            Avalon word address
//  chipselect  in   1                 Avalon select
//  write_n     in   1                 Avalon write strobe, active low
//  writedata   in   DATA_W            Avalon write data
//  byteenable  in   DATA_W/8          byte lanes; used only when NMR_PARAM_BYTEEN_EN is defined
//  readdata    out  DATA_W            Avalon read data, combinational on address
//  seq_idle    in   1                 sequencer idle; a commit may apply only while high
//  params_out  out  NUM_REGS*DATA_W   active parameters, reg i at [i*DATA_W +: DATA_W]
//  pending     out  1                 commit requested, not yet applied
//  commit_done out  1                 one-cycle pulse on the cycle after active regs update
// BEHAVIOUR
//  Interface: one clock, clk. reset is synchronous, active-high.
//  Address map
//   - addr 0..NUM_REGS-1: shadow[i], R/W.
//   - addr NUM_REGS: CTRL/STAT.
//     - write: bit0 COMMIT, bit1 ABORT, bit2 RDSEL.
//     - read: bit0 pending, bit2 RDSEL, bits[15:8] commit_cnt, others 0.
//   - Other addresses: read 0, writes ignored.
//   - Readback of addr i returns shadow[i] when RDSEL=0, active[i] when RDSEL=1.
//  Write
//   - Occurs when chipselect && !write_n.
//   - Shadow is updated at that edge; no wait states; read latency 0.
//  Reset
//   - shadow[i] and active[i] load RESET_VALS[i].
//   - pending=0, commit_done=0, RDSEL=0, commit_cnt=0, FSM=IDLE.
//  FSM
//   - IDLE -> PENDING on a CTRL write with COMMIT=1 and ABORT=0.
//   - PENDING -> IDLE on a CTRL write with ABORT=1 (no copy).
//   - PENDING -> IDLE when seq_idle=1: at that edge active[i] <= shadow[i] for all i,
//     commit_cnt += 1 (8-bit, wraps 255->0), commit_done=1 for the next cycle.
//   - COMMIT while already PENDING: ignored, still a single copy.
//   - COMMIT and ABORT in the same write: ABORT wins. In IDLE this is a no-op.
//  Timing
//   - Commit written at edge N: pending=1 after N.
//   - If seq_idle=1 before edge N+1, active updates at N+1, commit_done=1 during N+1..N+2,
//     pending=0 after N+1.
//   - If seq_idle stays 0, pending holds indefinitely.
//  Same-edge collisions
//   - A shadow write on the copy edge: active takes the pre-write shadow; the new value stays in shadow.
//   - An ABORT write on the copy edge: the copy completes and ABORT is ignored.
//  Reset mid-PENDING: the pending copy is discarded and every register returns to RESET_VALS.
// CONFIGURATION
//  NMR_PARAM_BYTEEN_EN
//   - Defined: shadow byte lane b is written only when byteenable[b]=1. CTRL bits apply only when byteenable[0]=1.
//   - Undefined: byteenable is ignored and full-word writes always apply.
// STRUCTURE
//  nmr_param_pkg holds:
//   - CTRL bit indices (CTRL_COMMIT=0, CTRL_ABORT=1, CTRL_RDSEL=2)
//   - COMMIT_CNT_LSB=8
//   - FSM state typedef {ST_IDLE, ST_PENDING}
//  One sub-module: nmr_param_reg, a single shadow+active register pair with byte-lane write,
//  load strobe and reset value. It is instantiated NUM_REGS times in a generate loop.
// TESTING
//  1. Reset, NUM_REGS=4, DATA_W=32 -> every addr 0..3 reads 255; params_out all 255; pending=0; STAT=0.
//  2. Write addr2=0x1000, RDSEL=0 -> read addr2=0x1000, params_out[2] still 255;
//     after COMMIT with seq_idle=1 -> params_out[2]=0x1000 one edge later, one commit_done pulse, cnt=1.
//  3. seq_idle=0, COMMIT -> pending=1 and held for 50 cycles, params unchanged;
//     raise seq_idle -> copy on the next edge, pending=0.
//  4. PENDING with seq_idle=0, write CTRL=0x3 -> pending=0, no copy, cnt unchanged;
//     then a shadow write on the copy edge -> active has the old value, shadow the new.
//  5. 256 commits -> commit_cnt wraps to 0; assert reset while pending -> all 255, pending=0, no commit_done.
//  6. With NMR_PARAM_BYTEEN_EN: write 0xAABBCCDD with byteenable=4'b0101 to addr0=0
//     -> reads 0x00BB00DD. Without the macro -> reads 0xAABBCCDD.

Source files
------------

// File: rtl/nmr_param_pkg.sv
// rtl/nmr_param_pkg.sv - shared constants and FSM state type for the NMR parameter bank
package nmr_param_pkg;

    // CTRL/STAT register bit positions
    localparam int CTRL_COMMIT    = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int CTRL_RDSEL     = 2;
    localparam int COMMIT_CNT_LSB = 8;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

endpackage

// File: rtl/nmr_param_bank_if.sv
// rtl/nmr_param_bank_if.sv - Avalon-MM slave bus bundle for the NMR parameter bank
interface nmr_param_bank_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                write_n;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, chipselect, write_n, writedata, byteenable,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata, byteenable,
        output readdata
    );
endinterface

// File: rtl/nmr_param_reg.sv
// rtl/nmr_param_reg.sv - one shadow/active parameter register pair with byte-lane writes
module nmr_param_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] lane_en,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                load,
    output logic [DATA_W-1:0]   shadow,
    output logic [DATA_W-1:0]   active
);

    // Active copies the pre-write shadow when load and a write share an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= RESET_VAL;
            active <= RESET_VAL;
        end else begin
            if (load)
                active <= shadow;
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_en && lane_en[b])
                    shadow[b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/nmr_param_bank.sv
// rtl/nmr_param_bank.sv - shadowed NMR parameter bank with idle-gated atomic commit (option: NMR_PARAM_BYTEEN_EN)
module nmr_param_bank
    import nmr_param_pkg::*;
#(
    parameter int                     NUM_REGS   = 8,
    parameter int                     DATA_W     = 32,
    parameter int                     ADDR_W     = $clog2(NUM_REGS+1),
    parameter logic [NUM_REGS*32-1:0] RESET_VALS = {NUM_REGS{32'd255}}
) (
    input  logic                       clk,
    input  logic                       reset,
    nmr_param_bank_if.slave            bus,
    input  logic                       seq_idle,
    output logic [NUM_REGS*DATA_W-1:0] params_out,
    output logic                       pending,
    output logic                       commit_done
);

    localparam int                NB        = DATA_W/8;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_REGS);

    state_t            state;
    logic              rdsel;
    logic [7:0]        commit_cnt;
    logic              wr;
    logic              ctrl_wr;
    logic              load;
    logic [NB-1:0]     lane_en;
    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];
    logic [31:0]       stat;

    assign wr = bus.chipselect && !bus.write_n;

`ifdef NMR_PARAM_BYTEEN_EN
    assign lane_en = bus.byteenable;
    assign ctrl_wr = wr && (bus.address == CTRL_ADDR) && bus.byteenable[0];
`else
    logic unused_byteenable;
    assign unused_byteenable = ^bus.byteenable;
    assign lane_en = '1;
    assign ctrl_wr = wr && (bus.address == CTRL_ADDR);
`endif

    // The copy edge is any edge where a commit is waiting and the sequencer is idle
    assign load = (state == ST_PENDING) && seq_idle;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            nmr_param_reg #(
                .DATA_W    (DATA_W),
                .RESET_VAL (RESET_VALS[i*32 +: DATA_W])
            ) u_reg (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (wr && (bus.address == ADDR_W'(i))),
                .lane_en (lane_en),
                .wdata   (bus.writedata),
                .load    (load),
                .shadow  (shadow[i]),
                .active  (active[i])
            );
            assign params_out[i*DATA_W +: DATA_W] = active[i];
        end
    endgenerate

    // Commit FSM; a copy takes priority over an ABORT arriving on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            commit_done <= 1'b0;
            rdsel       <= 1'b0;
            commit_cnt  <= 8'd0;
        end else begin
            commit_done <= 1'b0;
            if (ctrl_wr)
                rdsel <= bus.writedata[CTRL_RDSEL];
            case (state)
                ST_IDLE: begin
                    if (ctrl_wr && bus.writedata[CTRL_COMMIT] && !bus.writedata[CTRL_ABORT]) begin
                        state   <= ST_PENDING;
                        pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (seq_idle) begin
                        state       <= ST_IDLE;
                        pending     <= 1'b0;
                        commit_cnt  <= commit_cnt + 8'd1;
                        commit_done <= 1'b1;
                    end else if (ctrl_wr && bus.writedata[CTRL_ABORT]) begin
                        state   <= ST_IDLE;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency readback; CTRL/STAT is assembled at 32 bits and truncated to the bus
    always_comb begin
        stat                            = '0;
        stat[CTRL_COMMIT]               = pending;
        stat[CTRL_RDSEL]                = rdsel;
        stat[COMMIT_CNT_LSB +: 8]       = commit_cnt;
        bus.readdata                    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.address == ADDR_W'(i))
                bus.readdata = rdsel ? active[i] : shadow[i];
        end
        if (bus.address == CTRL_ADDR)
            bus.readdata = stat[DATA_W-1:0];
    end

endmodule

// File: tb/tb_nmr_param_bank.sv
// tb/tb_nmr_param_bank.sv - self-checking bench for nmr_param_bank (honours NMR_PARAM_BYTEEN_EN)
module tb_nmr_param_bank;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 3;

    logic           clk;
    logic           reset;
    logic           seq_idle;
    logic [N*DW-1:0] params_out;
    logic           pending;
    logic           commit_done;

    int n_pass  = 0;
    int n_total = 0;

    nmr_param_bank_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

    nmr_param_bank #(.NUM_REGS(N), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (ifc),
        .seq_idle    (seq_idle),
        .params_out  (params_out),
        .pending     (pending),
        .commit_done (commit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the register map
    logic [31:0] sh_m [N];
    logic [31:0] ac_m [N];
    logic        pend_m, done_m, rdsel_m;
    logic [7:0]  cnt_m;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh_m[i] = 32'd255;
            ac_m[i] = 32'd255;
        end
        pend_m = 0; done_m = 0; rdsel_m = 0; cnt_m = 0;
    endtask

    task automatic model_step(input logic r, cs, wn, input logic [2:0] a,
                              input logic [31:0] d, input logic [3:0] be, input logic idle);
        logic wr, ctrl;
        logic [3:0] lanes;
        if (r) begin
            model_reset();
        end else begin
            wr = cs && !wn;
`ifdef NMR_PARAM_BYTEEN_EN
            lanes = be;
            ctrl  = wr && (a == 3'd4) && be[0];
`else
            lanes = 4'hF;
            ctrl  = wr && (a == 3'd4);
`endif
            done_m = 0;
            if (pend_m && idle) begin
                for (int i = 0; i < N; i++) ac_m[i] = sh_m[i];
                cnt_m  = cnt_m + 8'd1;
                pend_m = 0;
                done_m = 1;
            end else if (pend_m && ctrl && d[1]) begin
                pend_m = 0;
            end else if (!pend_m && ctrl && d[0] && !d[1]) begin
                pend_m = 1;
            end
            if (ctrl) rdsel_m = d[2];
            if (wr && a < 3'd4)
                for (int b = 0; b < 4; b++)
                    if (lanes[b]) sh_m[a][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        if (a < 3'd4)  return rdsel_m ? ac_m[a] : sh_m[a];
        if (a == 3'd4) return {16'd0, cnt_m, 5'd0, rdsel_m, 1'b0, pend_m};
        return 32'd0;
    endfunction

    function automatic logic [N*DW-1:0] model_params();
        logic [N*DW-1:0] p;
        for (int i = 0; i < N; i++) p[i*32 +: 32] = ac_m[i];
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock: drive just after negedge, check readback, step model at posedge, check outputs
    task automatic cyc(input logic r, cs, wn, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic idle, output logic [31:0] rd);
        reset          = r;
        ifc.chipselect = cs;
        ifc.write_n    = wn;
        ifc.address    = a;
        ifc.writedata  = d;
        ifc.byteenable = be;
        seq_idle       = idle;
        #1;
        rd = ifc.readdata;
        chk("readdata", rd, model_read(a));
        @(posedge clk);
        model_step(r, cs, wn, a, d, be, idle);
        @(negedge clk);
        chk("pending", pending, pend_m);
        chk("commit_done", commit_done, done_m);
        chk("params_out", params_out, model_params());
    endtask

    task automatic wr_cyc(input logic [2:0] a, input logic [31:0] d, input logic idle);
        logic [31:0] rd;
        cyc(1'b0, 1'b1, 1'b0, a, d, 4'hF, idle, rd);
    endtask

    task automatic rd_cyc(input logic [2:0] a, input logic idle, output logic [31:0] rd);
        cyc(1'b0, 1'b0, 1'b1, a, 32'd0, 4'hF, idle, rd);
    endtask

    typedef struct {
        logic        cs;
        logic        wn;
        logic [2:0]  a;
        logic [31:0] d;
        logic        idle;
        logic [31:0] exp_rd;
        logic        exp_pend;
        logic        exp_done;
        logic [31:0] exp_p2;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] rd;
        logic [7:0]  cnt_save;

        tbl[0]  = '{1'b0, 1'b1, 3'd0, 32'h0,    1'b1, 32'd255,   1'b0, 1'b0, 32'd255};
        tbl[1]  = '{1'b0, 1'b1, 3'd3, 32'h0,    1'b1, 32'd255,   1'b0, 1'b0, 32'd255};
        tbl[2]  = '{1'b0, 1'b1, 3'd4, 32'h0,    1'b1, 32'h0,     1'b0, 1'b0, 32'd255};
        tbl[3]  = '{1'b0, 1'b1, 3'd5, 32'h0,    1'b1, 32'h0,     1'b0, 1'b0, 32'd255};
        tbl[4]  = '{1'b1, 1'b0, 3'd2, 32'h1000, 1'b1, 32'd255,   1'b0, 1'b0, 32'd255};
        tbl[5]  = '{1'b0, 1'b1, 3'd2, 32'h0,    1'b1, 32'h1000,  1'b0, 1'b0, 32'd255};
        tbl[6]  = '{1'b1, 1'b0, 3'd4, 32'h1,    1'b0, 32'h0,     1'b1, 1'b0, 32'd255};
        tbl[7]  = '{1'b0, 1'b1, 3'd4, 32'h0,    1'b1, 32'h1,     1'b0, 1'b1, 32'h1000};
        tbl[8]  = '{1'b0, 1'b1, 3'd4, 32'h0,    1'b1, 32'h100,   1'b0, 1'b0, 32'h1000};
        tbl[9]  = '{1'b1, 1'b0, 3'd4, 32'h4,    1'b1, 32'h100,   1'b0, 1'b0, 32'h1000};
        tbl[10] = '{1'b0, 1'b1, 3'd2, 32'h0,    1'b1, 32'h1000,  1'b0, 1'b0, 32'h1000};
        tbl[11] = '{1'b0, 1'b1, 3'd4, 32'h0,    1'b1, 32'h104,   1'b0, 1'b0, 32'h1000};
        tbl[12] = '{1'b1, 1'b0, 3'd4, 32'h0,    1'b1, 32'h104,   1'b0, 1'b0, 32'h1000};

        reset = 1'b1; seq_idle = 1'b1;
        ifc.chipselect = 1'b0; ifc.write_n = 1'b1; ifc.address = '0;
        ifc.writedata = '0; ifc.byteenable = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("reset_params", params_out, {N{32'd255}});
        chk("reset_pending", pending, 1'b0);

        // Reset readback, first write and first commit
        for (int k = 0; k < 13; k++) begin
            cyc(1'b0, tbl[k].cs, tbl[k].wn, tbl[k].a, tbl[k].d, 4'hF, tbl[k].idle, rd);
            chk($sformatf("tbl%0d_rd", k), rd, tbl[k].exp_rd);
            chk($sformatf("tbl%0d_pend", k), pending, tbl[k].exp_pend);
            chk($sformatf("tbl%0d_done", k), commit_done, tbl[k].exp_done);
            chk($sformatf("tbl%0d_p2", k), params_out[2*32 +: 32], tbl[k].exp_p2);
        end

        // Commit held off by a busy sequencer, shadows keep changing underneath
        wr_cyc(3'd4, 32'h1, 1'b0);
        for (int k = 0; k < 50; k++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 3'($urandom_range(0, 3)), $urandom,
                4'hF, 1'b0, rd);
            chk("hold_pending", pending, 1'b1);
        end
        rd_cyc(3'd0, 1'b1, rd);
        chk("hold_release_pend", pending, 1'b0);
        chk("hold_release_done", commit_done, 1'b1);

        // Abort while pending: no copy, count unchanged
        cnt_save = cnt_m;
        wr_cyc(3'd4, 32'h1, 1'b0);
        wr_cyc(3'd4, 32'h3, 1'b0);
        chk("abort_pend", pending, 1'b0);
        chk("abort_done", commit_done, 1'b0);
        rd_cyc(3'd4, 1'b1, rd);
        chk("abort_cnt", rd[15:8], cnt_save);

        // Shadow write on the copy edge
        wr_cyc(3'd1, 32'h12345678, 1'b0);
        wr_cyc(3'd4, 32'h1, 1'b0);
        wr_cyc(3'd1, 32'hCAFEF00D, 1'b1);
        chk("collide_active", params_out[1*32 +: 32], 32'h12345678);
        rd_cyc(3'd1, 1'b1, rd);
        chk("collide_shadow", rd, 32'hCAFEF00D);

        // ABORT on the copy edge is ignored
        wr_cyc(3'd4, 32'h1, 1'b0);
        wr_cyc(3'd4, 32'h2, 1'b1);
        chk("abort_copy_done", commit_done, 1'b1);
        chk("abort_copy_active", params_out[1*32 +: 32], 32'hCAFEF00D);

        // COMMIT+ABORT in IDLE is a no-op; repeated COMMIT gives one copy
        wr_cyc(3'd4, 32'h3, 1'b0);
        chk("ca_idle_pend", pending, 1'b0);
        wr_cyc(3'd4, 32'h1, 1'b0);
        wr_cyc(3'd4, 32'h1, 1'b0);
        rd_cyc(3'd0, 1'b1, rd);
        chk("dup_done", commit_done, 1'b1);
        rd_cyc(3'd0, 1'b1, rd);
        chk("dup_single", commit_done, 1'b0);

        // Counter wrap after 256 commits from reset
        cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 4'hF, 1'b1, rd);
        for (int k = 0; k < 255; k++) begin
            wr_cyc(3'd4, 32'h1, 1'b1);
            rd_cyc(3'd0, 1'b1, rd);
        end
        rd_cyc(3'd4, 1'b1, rd);
        chk("cnt_255", rd[15:8], 8'd255);
        wr_cyc(3'd4, 32'h1, 1'b1);
        rd_cyc(3'd0, 1'b1, rd);
        rd_cyc(3'd4, 1'b1, rd);
        chk("cnt_wrap", rd[15:8], 8'd0);

        // Reset while pending discards the copy
        wr_cyc(3'd0, 32'h55, 1'b1);
        wr_cyc(3'd4, 32'h1, 1'b0);
        chk("pre_rst_pend", pending, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 4'hF, 1'b1, rd);
        chk("rst_pend", pending, 1'b0);
        chk("rst_done", commit_done, 1'b0);
        chk("rst_params", params_out, {N{32'd255}});
        rd_cyc(3'd0, 1'b1, rd);
        chk("rst_done2", commit_done, 1'b0);
        chk("rst_shadow", rd, 32'd255);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom,
                4'($urandom), 1'($urandom_range(0, 3) == 0), rd);
        end

        // Byte-lane write
        wr_cyc(3'd4, 32'h0, 1'b0);
        wr_cyc(3'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 32'hAABBCCDD, 4'b0101, 1'b0, rd);
        rd_cyc(3'd0, 1'b0, rd);
`ifdef NMR_PARAM_BYTEEN_EN
        chk("byteen", rd, 32'h00BB00DD);
`else
        chk("byteen", rd, 32'hAABBCCDD);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
